insertion_buffer: RTL
=====================

// Module: insertion_buffer
// PURPOSE
//  Second-generation insertion stage for the SVM scheduler front end. Sits between the transaction
//  source and the conflict-check pipeline. Buffers transactions (programID + read/write dependency
//  bitmaps) in a parametrised circular FIFO feeding a registered output slot, and preserves strict
//  arrival order. Adds flush, almost-full back-signalling, a high-watermark and a stall counter.
//  Has no watchdog or timeout path.
// PARAMETERS
//  MAX_DEPENDENCIES    256  width of each read/write dependency bitmap
//  PROGRAM_ID_W        64   width of owner programID
//  DEPTH               8    ring entries; power of 2, >=2; total capacity = DEPTH+1 (ring + output slot)
//  ALMOST_FULL_THRESH  6    almost_full asserts when occupancy >= this value; range 1..DEPTH+1
//  OCC_W               $clog2(DEPTH+2)  occupancy / watermark width (derived localparam)
// PORTS
//  clk                             in   1                 clock, rising edge
//  rst                             in   1                 asynchronous, active-high reset
//  s_axis_tvalid                   in   1                 input transaction valid
//  s_axis_tready                   out  1                 input ready
//  s_axis_tdata_owner_programID    in   PROGRAM_ID_W      input programID
//  s_axis_tdata_read_dependencies  in   MAX_DEPENDENCIES  input read bitmap
//  s_axis_tdata_write_dependencies in   MAX_DEPENDENCIES  input write bitmap
//  m_axis_tvalid                   out  1                 output valid (registered)
//  m_axis_tready                   in   1                 downstream ready
//  m_axis_tdata_owner_programID    out  PROGRAM_ID_W      output programID (registered)
//  m_axis_tdata_read_dependencies  out  MAX_DEPENDENCIES  output read bitmap (registered)
//  m_axis_tdata_write_dependencies out  MAX_DEPENDENCIES  output write bitmap (registered)
//  flush                           in   1                 single-cycle pulse; discard all held transactions
//  hwm_clear                       in   1                 clear the high-watermark register
//  queue_occupancy                 out  OCC_W             ring count + m_axis_tvalid
//  almost_full                     out  1                 queue_occupancy >= ALMOST_FULL_THRESH
//  high_watermark                  out  OCC_W             max queue_occupancy since reset/hwm_clear
//  stall_cycles                    out  32                cycles with m_axis_tvalid & !m_axis_tready; saturates
// BEHAVIOUR
//  - Reset: every output is 0 (s_axis_tready is 0 while rst is high), ring head/tail/count are 0,
//    and storage contents are don't-care. s_axis_tready = 1 on the first cycle after rst deasserts.
//  - s_axis_tready = (ring_count != DEPTH) && !flush. It is registered-state based only; there is no
//    combinational path from m_axis_tready. When the ring is full, a same-cycle pop does not raise it.
//  - Accept = s_axis_tvalid & s_axis_tready. Pop = m_axis_tvalid & m_axis_tready.
//  - Output slot load, evaluated each cycle when the slot is empty or popping:
//      ring non-empty       -> slot <= ring[head]; head++ (the accepted input, if any, goes to ring[tail]);
//      ring empty & accept  -> slot <= input (bypass; input->m_axis_tvalid latency is 1 cycle);
//      otherwise            -> m_axis_tvalid <= 0.
//    When the slot is held (valid and not popped), an accepted input goes to ring[tail] and tail++.
//  - m_axis data is stable while m_axis_tvalid=1 and m_axis_tready=0. Valid never drops before a pop.
//  - Pointers are log2(DEPTH) bits and wrap naturally. ring_count is log2(DEPTH)+1 bits and
//    distinguishes full from empty. Simultaneous push and pop on the ring leaves the count unchanged.
//  - flush: the cycle's pop, if any, completes normally. On the next edge the ring and the slot are
//    cleared (m_axis_tvalid=0, occupancy=0). No input is accepted during the flush cycle.
//    high_watermark and stall_cycles are not changed by flush.
//  - high_watermark <= max(high_watermark, next queue_occupancy). hwm_clear loads the next occupancy.
//  - stall_cycles increments by 1 per stalled cycle and holds at 32'hFFFF_FFFF.
//  - Async reset asserted mid-transfer: in-flight and queued transactions are lost; no partial
//    outputs are produced.
// STRUCTURE
//  - Shared package svm_sched_pkg: MAX_DEPENDENCIES and PROGRAM_ID_W defaults, and the transaction
//    width constant TXN_W = PROGRAM_ID_W + 2*MAX_DEPENDENCIES (packed {id, rd, wr}).
//  - Sub-module insertion_ring: DEPTH x TXN_W storage, head/tail/count, push/pop/clear, full/empty.
//    The top level holds the output slot, bypass mux, flush and statistics.
// TESTING (DEPTH=8, ALMOST_FULL_THRESH=6)
//  - Empty pass-through: push ID=0x11 with m_ready=1 -> m_valid next cycle with ID 0x11; occupancy 1, then 0.
//  - Fill: m_ready=0, offer IDs 1..10 back-to-back -> 9 accepted (s_tready low after the 9th);
//    occupancy=9; almost_full high from occupancy 6; high_watermark=9.
//  - Drain order: release m_ready=1 -> IDs 1..9 in order, one per cycle; s_tready high the cycle after
//    the ring leaves full; stall_cycles = number of stalled cycles.
//  - Wrap: 20 random push/pop cycles crossing the pointer wrap twice -> output order matches a scoreboard.
//  - Flush: occupancy 5, pulse flush with m_ready=1 -> exactly 1 pop, then occupancy 0 and m_valid 0;
//    high_watermark unchanged; hwm_clear then gives 0.
//  - Reset mid-stream: assert rst with occupancy 4 -> all outputs 0 asynchronously; after release,
//    new ID 0x22 passes with 1-cycle latency.

Source files
------------

// File: rtl/svm_sched_pkg.sv
// Shared scheduler front-end constants: default field widths and transaction packing width.
// No logic, so no latency.
// No flow control.
package svm_sched_pkg;

    localparam int MAX_DEPENDENCIES = 256;
    localparam int PROGRAM_ID_W     = 64;
    // Transactions travel packed as {owner programID, read bitmap, write bitmap}
    localparam int TXN_W            = PROGRAM_ID_W + 2 * MAX_DEPENDENCIES;

    // Packed transaction width for non-default field widths
    function automatic int txn_width(input int id_w, input int dep_w);
        return id_w + 2 * dep_w;
    endfunction

endpackage

// File: rtl/insertion_buffer_if.sv
// One transaction stream: valid/ready handshake plus programID and dependency bitmaps.
// Wires only, so no latency.
// The receiver throttles the sender through tready.
interface insertion_buffer_if #(
    parameter int PROGRAM_ID_W     = svm_sched_pkg::PROGRAM_ID_W,
    parameter int MAX_DEPENDENCIES = svm_sched_pkg::MAX_DEPENDENCIES
);
    logic                        tvalid;
    logic                        tready;
    logic [PROGRAM_ID_W-1:0]     tdata_owner_programID;
    logic [MAX_DEPENDENCIES-1:0] tdata_read_dependencies;
    logic [MAX_DEPENDENCIES-1:0] tdata_write_dependencies;

    modport master (
        output tvalid, tdata_owner_programID, tdata_read_dependencies, tdata_write_dependencies,
        input  tready
    );

    modport slave (
        input  tvalid, tdata_owner_programID, tdata_read_dependencies, tdata_write_dependencies,
        output tready
    );
endinterface

// File: rtl/insertion_ring.sv
// Circular FIFO storage: DEPTH entries with head/tail pointers and an extra-bit occupancy count.
// The head entry is readable combinationally; a push is visible at the head one cycle later.
// No internal backpressure: the caller must not push when full or pop when empty.
module insertion_ring
    import svm_sched_pkg::*;
#(
    parameter int W     = TXN_W,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    input  logic          clear,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    // Storage needs no reset; only entries between head and tail are ever read
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail] <= push_dat;
        end
    end

    // Pointers wrap naturally at a power-of-two depth; count carries the full/empty distinction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem[head];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
endmodule

// File: rtl/insertion_buffer.sv
// Order-preserving insertion buffer: ring FIFO feeding a registered output slot, plus flush and stats.
// Empty-queue input reaches m_axis one cycle after acceptance; otherwise strictly in arrival order.
// s_axis.tready drops only when the ring is full or during flush; it never looks at m_axis.tready.
module insertion_buffer
    import svm_sched_pkg::*;
#(
    parameter int MAX_DEPENDENCIES   = svm_sched_pkg::MAX_DEPENDENCIES,
    parameter int PROGRAM_ID_W       = svm_sched_pkg::PROGRAM_ID_W,
    parameter int DEPTH              = 8,
    parameter int ALMOST_FULL_THRESH = 6,
    localparam int OCC_W             = $clog2(DEPTH + 2)
) (
    input  logic               clk,
    input  logic               rst,
    insertion_buffer_if.slave  s_axis,
    insertion_buffer_if.master m_axis,
    input  logic               flush,
    input  logic               hwm_clear,
    output logic [OCC_W-1:0]   queue_occupancy,
    output logic               almost_full,
    output logic [OCC_W-1:0]   high_watermark,
    output logic [31:0]        stall_cycles
);
    localparam int TW = txn_width(PROGRAM_ID_W, MAX_DEPENDENCIES);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [TW-1:0]    in_dat;
    logic [TW-1:0]    ring_dat;
    logic [TW-1:0]    slot_dat;
    logic             slot_vld;
    logic [CW-1:0]    ring_count;
    logic             ring_full;
    logic             ring_empty;
    logic             s_rdy;
    logic             accept;
    logic             out_pop;
    logic             slot_free;
    logic             ring_push;
    logic             ring_pop;
    logic             vld_nxt;
    logic [CW-1:0]    ring_count_nxt;
    logic [OCC_W-1:0] occ_nxt;

    assign in_dat = {s_axis.tdata_owner_programID, s_axis.tdata_read_dependencies,
                     s_axis.tdata_write_dependencies};

    // Ready comes from registered ring state only; a pop into a full ring frees space next cycle
    assign s_rdy     = !rst && !ring_full && !flush;
    assign accept    = s_axis.tvalid && s_rdy;
    assign out_pop   = slot_vld && m_axis.tready;
    assign slot_free = !slot_vld || out_pop;

    // Refill the slot from the ring first; an input skips the ring only when nothing is queued ahead
    assign ring_pop  = slot_free && !ring_empty && !flush;
    assign ring_push = accept && !(slot_free && ring_empty);

    insertion_ring #(
        .W     (TW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .push     (ring_push),
        .push_dat (in_dat),
        .pop      (ring_pop),
        .clear    (flush),
        .head_dat (ring_dat),
        .count    (ring_count),
        .full     (ring_full),
        .empty    (ring_empty)
    );

    // Output slot: hold while stalled, reload from ring or bypass when free, drop on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld <= 1'b0;
            slot_dat <= '0;
        end else if (flush) begin
            slot_vld <= 1'b0;
        end else if (slot_free) begin
            if (!ring_empty) begin
                slot_vld <= 1'b1;
                slot_dat <= ring_dat;
            end else if (accept) begin
                slot_vld <= 1'b1;
                slot_dat <= in_dat;
            end else begin
                slot_vld <= 1'b0;
            end
        end
    end

    // Next-cycle occupancy, used so the watermark tracks the value the outputs will show
    always_comb begin
        vld_nxt        = 1'b1;
        ring_count_nxt = ring_count + CW'(ring_push) - CW'(ring_pop);
        if (flush) begin
            vld_nxt        = 1'b0;
            ring_count_nxt = '0;
        end else if (slot_free) begin
            vld_nxt = !ring_empty || accept;
        end
        occ_nxt = OCC_W'(ring_count_nxt) + OCC_W'(vld_nxt);
    end

    // High watermark: running maximum, or reload with the next occupancy on hwm_clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_watermark <= '0;
        end else if (hwm_clear || (occ_nxt > high_watermark)) begin
            high_watermark <= occ_nxt;
        end
    end

    // Stall counter: downstream refused a valid transaction; saturates rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (slot_vld && !m_axis.tready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

    assign s_axis.tready  = s_rdy;
    assign m_axis.tvalid  = slot_vld;
    assign {m_axis.tdata_owner_programID, m_axis.tdata_read_dependencies,
            m_axis.tdata_write_dependencies} = slot_dat;

    assign queue_occupancy = OCC_W'(ring_count) + OCC_W'(slot_vld);
    assign almost_full     = (queue_occupancy >= OCC_W'(ALMOST_FULL_THRESH));
endmodule
